// File: rtl/ghost_dir_sched.sv
// ghost_dir_sched: round-robin direction scheduler for four ghosts, plus the scatter/chase mode timer.
// Latency: a ghost evaluated this frame shows its new keycode on the next frame_clk edge; mode and reversal share one edge.
// Backpressure: none; freeze holds all state, restart clears it synchronously, Reset (async, active-high) clears it at once.
// Ports: frame_clk, Reset, restart, freeze, sec (1 Hz pulse), rnd (only [1:0] used), walls ({L,R,B,T} for ghost sel) in;
//        sel (ghost under evaluation), keycodes (ghost i at [8i+7:8i]), mode (0 scatter, 1 chase) out.
module ghost_dir_sched #(
    parameter int NGHOST      = 4,
    parameter int HOLD_FRAMES = 16,
    parameter int SCATTER_S   = 7,
    parameter int CHASE_S     = 20
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        restart,
    input  logic        freeze,
    input  logic        sec,
    input  logic [7:0]  rnd,
    input  logic [3:0]  walls,
    output logic [1:0]  sel,
    output logic [31:0] keycodes,
    output logic        mode
);

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_U = 2'd3;

    localparam logic [NGHOST-1:0][1:0] DIR_INIT = {DIR_D, DIR_U, DIR_R, DIR_L};
    localparam logic [31:0] KEY_INIT    = 32'h161A_0704;
    localparam logic [5:0]  HOLD_AGE    = 6'(HOLD_FRAMES);
    localparam logic [4:0]  SCATTER_END = 5'(SCATTER_S - 1);
    localparam logic [4:0]  CHASE_END   = 5'(CHASE_S - 1);

    typedef enum logic {SCATTER = 1'b0, CHASE = 1'b1} mode_e;

    function automatic logic blocked(input logic [1:0] d, input logic [3:0] w);
        case (d)
            DIR_L:   return w[3];
            DIR_R:   return w[2];
            DIR_D:   return w[1];
            default: return w[0];
        endcase
    endfunction

    function automatic logic [7:0] keycode_of(input logic [1:0] d);
        case (d)
            DIR_L:   return 8'h04;
            DIR_R:   return 8'h07;
            DIR_D:   return 8'h16;
            default: return 8'h1A;
        endcase
    endfunction

    logic [NGHOST-1:0][1:0] dir_q, dir_d;
    logic [NGHOST-1:0][5:0] age_q, age_d;
    logic [1:0]             sel_q, sel_d;
    logic [4:0]             timer_q, timer_d;
    mode_e                  state_q, state_d;
    logic [31:0]            keycodes_q, keycodes_d;

    logic [1:0] cur_dir, rev_dir, pick_dir, cand;
    logic       found;
    logic       mode_flip;
    logic [4:0] term_val;

    // Only the low two random bits pick the scan start.
    logic unused_rnd;
    assign unused_rnd = ^rnd[7:2];

    // Direction choice for the ghost at sel. The current direction is kept
    // while open and young; otherwise scan from rnd, never reversing unless
    // the reverse is the only way out.
    always_comb begin
        cur_dir  = dir_q[sel_q];
        rev_dir  = cur_dir ^ 2'd1;
        pick_dir = cur_dir;
        found    = 1'b0;
        cand     = rnd[1:0];
        if (blocked(cur_dir, walls) || (age_q[sel_q] >= HOLD_AGE)) begin
            for (int k = 0; k < 4; k++) begin
                cand = rnd[1:0] + 2'(k);
                if (!found && !blocked(cand, walls) && (cand != rev_dir)) begin
                    pick_dir = cand;
                    found    = 1'b1;
                end
            end
            if (!found && !blocked(rev_dir, walls)) begin
                pick_dir = rev_dir;
            end
        end
    end

    // Mode FSM next state; the timer counts sec pulses within the current mode.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        term_val  = (state_q == CHASE) ? CHASE_END : SCATTER_END;
        mode_flip = sec && (timer_q == term_val);
        if (restart) begin
            state_d = SCATTER;
            timer_d = '0;
        end else if (!freeze) begin
            if (mode_flip) begin
                state_d = (state_q == SCATTER) ? CHASE : SCATTER;
                timer_d = '0;
            end else if (sec) begin
                timer_d = timer_q + 5'd1;
            end
        end
    end

    // Ghost state next state. A mode flip reverses everyone blindly (other
    // ghosts' walls are not visible) and replaces this frame's evaluation.
    always_comb begin
        dir_d = dir_q;
        age_d = age_q;
        sel_d = sel_q;
        if (restart) begin
            dir_d = DIR_INIT;
            age_d = '0;
            sel_d = 2'd0;
        end else if (!freeze) begin
            sel_d = sel_q + 2'd1;
            for (int i = 0; i < NGHOST; i++) begin
                age_d[i] = (age_q[i] == 6'd63) ? age_q[i] : age_q[i] + 6'd1;
            end
            if (mode_flip) begin
                for (int i = 0; i < NGHOST; i++) begin
                    dir_d[i] = dir_q[i] ^ 2'd1;
                    age_d[i] = '0;
                end
            end else if (pick_dir != cur_dir) begin
                dir_d[sel_q] = pick_dir;
                age_d[sel_q] = '0;
            end
        end
    end

    always_comb begin
        keycodes_d = '0;
        for (int i = 0; i < NGHOST; i++) begin
            keycodes_d[8*i +: 8] = keycode_of(dir_d[i]);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dir_q      <= DIR_INIT;
            age_q      <= '0;
            sel_q      <= 2'd0;
            timer_q    <= '0;
            state_q    <= SCATTER;
            keycodes_q <= KEY_INIT;
        end else begin
            dir_q      <= dir_d;
            age_q      <= age_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            keycodes_q <= keycodes_d;
        end
    end

    assign sel      = sel_q;
    assign keycodes = keycodes_q;
    assign mode     = (state_q == CHASE);

endmodule

// File: doc/ghost_dir_sched.md
# ghost_dir_sched

Round-robin direction scheduler for the four maze ghosts. Each frame it selects one ghost, reads that ghost's wall flags through a single shared map-lookup port, and registers a new direction keycode from a random byte. It also runs the scatter/chase mode timer from the 1 Hz `sec` pulse. The per-ghost keycodes drive the `randomkeycode` inputs of the ghost movement blocks. The mux that routes the selected ghost's `mapL/mapR/mapB/mapT` onto `walls` lives outside this block.

## Interface
- `NGHOST`, 4: number of ghosts scheduled; fixed at 4, since `sel` is 2 bits.
- `HOLD_FRAMES`, 16: minimum frames a ghost keeps an unblocked direction before it may change; range 1..63.
- `SCATTER_S`, 7: scatter-mode duration, in `sec` pulses; range 1..31.
- `CHASE_S`, 20: chase-mode duration, in `sec` pulses; range 1..31.
- `frame_clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  reset Reset, asynchronous, active-high; clock frame_clk.
- `restart`  in  1  synchronous clear to the reset state; level-sensitive.
- `freeze`  in  1  when high, all state holds (used during life loss).
- `sec`  in  1  one-frame pulse per second, synchronous to `frame_clk`.
- `rnd`  in  8  random byte; only `rnd[1:0]` is used.
- `walls`  in  4  combinational wall flags for ghost `sel`: {L,R,B,T}; 1 means blocked.
- `sel`  out  2  ghost currently being evaluated.
- `keycodes`  out  32  packed keycodes; ghost i is at `[8i+7:8i]`.
- `mode`  out  1  0 = scatter, 1 = chase.

## Operation
- **Direction encoding (2-bit `dir`):**
  - 0 = L, keycode 8'h04; blocked when `walls[3]`.
  - 1 = R, keycode 8'h07; blocked when `walls[2]`.
  - 2 = D, keycode 8'h16; blocked when `walls[1]`.
  - 3 = U, keycode 8'h1A; blocked when `walls[0]`.
  - Reverse direction = `dir ^ 1`.
- **Per-ghost state:**
  - `dir[i]`, 2 bits.
  - `age[i]`, 6-bit counter; saturates at 63.
  - Keycodes are a pure decode of `dir[i]` and are registered.
- **Reset/restart state:**
  - `dir` = {0: L, 1: R, 2: U, 3: D}.
  - All `age` = 0, `sel` = 0, `mode` = 0, mode timer = 0.
  - Resulting `keycodes` = 32'h16_1A_07_04.
- **Each unfrozen frame:**
  - Every `age[i]` increments (saturating).
  - `sel` advances 0→1→2→3→0.
  - The ghost at the current `sel` is evaluated.
- **Evaluation of ghost s = `sel`:**
  - If `dir[s]` is unblocked and `age[s] < HOLD_FRAMES`: no change.
  - Otherwise, scan c = `rnd[1:0]`, c+1, c+2, c+3 (mod 4). The first direction that is unblocked and not the reverse of `dir[s]` is chosen.
  - If no direction qualifies, choose the reverse, if it is unblocked.
  - If all four directions are blocked, keep `dir[s]`.
  - If the chosen direction differs from `dir[s]`: update it and clear `age[s]` to 0; this overrides the increment.
  - If the chosen direction equals `dir[s]`: `age` still increments.
- **Mode FSM: states SCATTER and CHASE.**
  - Timer (5-bit) increments on `sec` while unfrozen.
  - In SCATTER, when the timer equals `SCATTER_S-1` and `sec` is high: go to CHASE and clear the timer.
  - In CHASE, the same rule applies with `CHASE_S-1`, returning to SCATTER.
- **Mode transition cycle:**
  - Every ghost's `dir` is set to its reverse and every `age` cleared.
  - The walls of non-selected ghosts are unknown, so the reversal is unconditional.
  - The normal evaluation of `sel` is suppressed that cycle.
  - `sel` still advances.
- **Priority:** `Reset` > `restart` > `freeze` > mode transition > evaluation.

## Timing
- `walls` is sampled in the same cycle `sel` presents it. The external lookup must be combinational from `sel`.
- Decision latency: the new keycode appears on the frame edge after evaluation.
- A given ghost is re-evaluated every 4 frames, so a blocked ghost changes direction within ≤4 frames.
- `mode` changes on the edge that consumes the terminal `sec` pulse. The reversed keycodes appear on that same edge.
- `freeze` high: `sel`, the timer, `age`, `dir` and `mode` all hold. A `sec` pulse during freeze is lost.
- `restart` asserted mid-scan: the block returns to the reset state next edge. `sel` restarts at 0.
- Asynchronous `Reset` takes effect immediately, regardless of `frame_clk`.

## Test plan
- **Reset values:** assert `Reset` → `keycodes` = 32'h161A0704, `sel` = 0, `mode` = 0; 4 frames later `sel` = 0 again.
- **Corridor hold:** `walls` = 4'b0011 (U/D blocked); ghost 0 is L and `rnd` = 2 each frame → ghost 0 stays 8'h04 until its age reaches 16. At the first evaluation with age ≥16, L is chosen again and `age` is not cleared.
- **Blocked turn:** `walls` = 4'b1000 at `sel` = 0, ghost 0 is L, `rnd` = 3 → U qualifies; ghost 0 keycode = 8'h1A next frame and `age[0]` = 0.
- **Dead end:** `walls` = 4'b1011 at `sel` = 0, ghost 0 is L → R is reversal-only; ghost 0 keycode = 8'h07. With `walls` = 4'b1111, the keycode stays 8'h04.
- **Mode switch:** 7 `sec` pulses from reset → `mode` = 1 on the 7th, and all keycodes reverse to 32'h1A160407. Then 20 more pulses → `mode` = 0.
- **Freeze:** hold `freeze` for 10 frames with `sec` pulses and blocked walls → no output changes. Then `restart` during freeze → reset values on the next edge.
